// File: rtl/multicycle_control_pkg.sv
// Shared types and constants for the multicycle controller and its watchdog.
package multicycle_control_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_ERROR  = 3'd6
  } state_t;

  localparam logic [1:0] PC_SRC_SEQ    = 2'b00;
  localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  localparam logic [5:0] OP_JAL = 6'h03;
  localparam logic [5:0] OP_BNE = 6'h05;

  typedef struct packed {
    logic       regwrite;
    logic       memread;
    logic       memwrite;
    logic       branch;
    logic       jump;
    logic [5:0] opcode;
  } dec_t;

endpackage

// File: rtl/multicycle_control_watchdog.sv
// Memory-wait watchdog: counts stalled cycles and flags when the limit is reached.
module mc_watchdog #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt;

  // expired is combinational so the controller can leave on the last waiting cycle
  assign expired = enable && (cnt >= CW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && !expired) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle CPU control FSM: fetch/decode/execute/memory/write-back sequencing.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             halt_req,
  input  logic             mem_ready,
  input  logic             dec_regwrite,
  input  logic             dec_memread,
  input  logic             dec_memwrite,
  input  logic             dec_branch,
  input  logic             dec_jump,
  input  logic [5:0]       dec_opcode,
  input  logic             alu_zero,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_sel,
  output logic             ir_load,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             rf_we,
  output logic             rf_link,
  output logic             wb_sel,
  output logic             busy,
  output logic             error,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instr_count
);

  state_t cur, nxt;
  dec_t   dec_q;
  logic   retire;
  logic   waiting;
  logic   wd_clear, wd_en, wd_expired;

  // The watchdog restarts whenever a request completes or no request is pending
  assign waiting  = (cur == S_FETCH) || (cur == S_MEM);
  assign wd_en    = waiting && !mem_ready;
  assign wd_clear = !waiting || mem_ready;

  mc_watchdog #(.TIMEOUT(MEM_TIMEOUT)) u_watchdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (wd_clear),
    .enable  (wd_en),
    .expired (wd_expired)
  );

  assign state = cur;
  assign busy  = (cur != S_IDLE) && (cur != S_ERROR);
  assign error = (cur == S_ERROR);

  always_comb begin
    nxt      = cur;
    retire   = 1'b0;
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    mem_sel  = 1'b0;
    ir_load  = 1'b0;
    pc_write = 1'b0;
    pc_src   = PC_SRC_SEQ;
    rf_we    = 1'b0;
    rf_link  = 1'b0;
    wb_sel   = 1'b0;
    case (cur)
      S_IDLE: if (start) nxt = S_FETCH;
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_load  = 1'b1;
          pc_write = 1'b1;
          nxt      = S_DECODE;
        end else if (wd_expired) begin
          nxt = S_ERROR;
        end
      end
      S_DECODE: nxt = S_EXEC;
      S_EXEC: begin
        if (dec_q.jump) begin
          pc_write = 1'b1;
          pc_src   = PC_SRC_JUMP;
          rf_we    = (dec_q.opcode == OP_JAL);
          rf_link  = (dec_q.opcode == OP_JAL);
          retire   = 1'b1;
        end else if (dec_q.branch) begin
          pc_write = alu_zero ^ (dec_q.opcode == OP_BNE);
          pc_src   = PC_SRC_BRANCH;
          retire   = 1'b1;
        end else if (dec_q.memread || dec_q.memwrite) begin
          nxt = S_MEM;
        end else if (dec_q.regwrite) begin
          nxt = S_WB;
        end else begin
          retire = 1'b1;
        end
      end
      S_MEM: begin
        mem_req = 1'b1;
        mem_sel = 1'b1;
        mem_we  = dec_q.memwrite;
        if (mem_ready) begin
          if (dec_q.memread) nxt = S_WB;
          else               retire = 1'b1;
        end else if (wd_expired) begin
          nxt = S_ERROR;
        end
      end
      S_WB: begin
        rf_we  = 1'b1;
        wb_sel = dec_q.memread;
        retire = 1'b1;
      end
      S_ERROR: nxt = S_ERROR;
      default: nxt = S_ERROR;
    endcase
    if (retire) nxt = halt_req ? S_IDLE : S_FETCH;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur         <= S_IDLE;
      instr_count <= '0;
      dec_q       <= '0;
    end else begin
      cur <= nxt;
      if (retire) instr_count <= instr_count + CNT_W'(1);
      if (cur == S_DECODE)
        dec_q <= '{regwrite: dec_regwrite, memread: dec_memread, memwrite: dec_memwrite,
                   branch: dec_branch, jump: dec_jump, opcode: dec_opcode};
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: instruction-level model vs observed control pulses.
module tb_multicycle_control;
  import multicycle_control_pkg::*;

  localparam int CNT_W = 4;
  localparam int TO    = 16;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, halt_req = 1'b0, mem_ready = 1'b0;
  logic dec_regwrite = 1'b0, dec_memread = 1'b0, dec_memwrite = 1'b0;
  logic dec_branch = 1'b0, dec_jump = 1'b0, alu_zero = 1'b0;
  logic [5:0] dec_opcode = '0;
  logic mem_req, mem_we, mem_sel, ir_load, pc_write, rf_we, rf_link, wb_sel, busy, error;
  logic [1:0] pc_src;
  logic [2:0] state;
  logic [CNT_W-1:0] instr_count;

  multicycle_control #(.MEM_TIMEOUT(TO), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .halt_req(halt_req), .mem_ready(mem_ready),
    .dec_regwrite(dec_regwrite), .dec_memread(dec_memread), .dec_memwrite(dec_memwrite),
    .dec_branch(dec_branch), .dec_jump(dec_jump), .dec_opcode(dec_opcode), .alu_zero(alu_zero),
    .mem_req(mem_req), .mem_we(mem_we), .mem_sel(mem_sel), .ir_load(ir_load),
    .pc_write(pc_write), .pc_src(pc_src), .rf_we(rf_we), .rf_link(rf_link), .wb_sel(wb_sel),
    .busy(busy), .error(error), .state(state), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  typedef enum int {T_ADD, T_LW, T_SW, T_BEQ, T_BNE, T_J, T_JAL, T_NOP} itype_t;
  typedef struct { int op; bit rw, mr, mw, br, jp, az, halt; int dlat; } instr_t;
  typedef struct { bit pcw; int pcsrc; int rfwe; bit link; bit wbsel; bit dmem; bit dwe;
                   bit dsel; int dcyc; int count; int st; } rec_t;

  instr_t prog[$];
  rec_t   exp_q[$];
  int checks = 0, fails = 0;
  int exp_count = 0;
  int data_lat = 0, fetch_lat = -1;
  bit withhold = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, required);
    end
  endtask

  function automatic instr_t mk(input int t, input bit halt, input int dlat, input bit az);
    instr_t i = '{default: 0};
    i.halt = halt; i.dlat = dlat; i.az = az;
    case (t)
      T_ADD: begin i.op = 'h00; i.rw = 1; end
      T_LW:  begin i.op = 'h23; i.mr = 1; i.rw = 1; end
      T_SW:  begin i.op = 'h2b; i.mw = 1; end
      T_BEQ: begin i.op = 'h04; i.br = 1; end
      T_BNE: begin i.op = 'h05; i.br = 1; end
      T_J:   begin i.op = 'h02; i.jp = 1; end
      T_JAL: begin i.op = 'h03; i.jp = 1; i.rw = 1; end
      default: i.op = 'h3f;
    endcase
    return i;
  endfunction

  // Instruction-level expectation: what each instruction class should do to PC, RF and memory
  function automatic rec_t model(input instr_t i);
    rec_t r = '{default: 0};
    if (i.jp) begin
      r.pcw = 1; r.pcsrc = 2;
      if (i.op == 3) begin r.rfwe = 1; r.link = 1; end
    end else if (i.br) begin
      r.pcw   = i.az ^ (i.op == 5);
      r.pcsrc = r.pcw ? 1 : 0;
    end else if (i.mr || i.mw) begin
      r.dmem = 1; r.dsel = 1; r.dwe = i.mw; r.dcyc = i.dlat + 1;
      if (i.mr) begin r.rfwe = 1; r.wbsel = 1; end
    end else if (i.rw) begin
      r.rfwe = 1;
    end
    r.st = i.halt ? 0 : 1;
    return r;
  endfunction

  // Feeder: presents the next instruction when it is fetched, scrambles decoder lines later
  initial begin : feeder
    instr_t i;
    rec_t r;
    forever begin
      @(negedge clk);
      if (rst_n && ir_load) begin
        i = (prog.size() > 0) ? prog.pop_front() : mk(T_NOP, 1'b1, 0, 1'b0);
        dec_regwrite = i.rw; dec_memread = i.mr; dec_memwrite = i.mw;
        dec_branch = i.br; dec_jump = i.jp; dec_opcode = 6'(i.op);
        alu_zero = i.az; halt_req = i.halt; data_lat = i.dlat;
        r = model(i);
        exp_count = (exp_count + 1) % (1 << CNT_W);
        r.count = exp_count;
        exp_q.push_back(r);
      end else if (state == 3'd3) begin
        {dec_regwrite, dec_memread, dec_memwrite, dec_branch, dec_jump} = 5'($urandom);
        dec_opcode = 6'($urandom);
      end
    end
  end

  // Memory responder: per-request latency, random noise on mem_ready while idle
  initial begin : responder
    bit hs, act;
    int waited, lat;
    act = 0; waited = 0; lat = 0;
    forever begin
      @(negedge clk);
      hs = mem_req && mem_ready;
      @(posedge clk);
      #1;
      if (!rst_n) begin
        mem_ready = 1'b0; act = 0;
      end else if (mem_req) begin
        if (hs || !act) begin
          act = 1; waited = 0;
          lat = mem_sel ? data_lat : (fetch_lat >= 0 ? fetch_lat : int'($urandom_range(0, 2)));
        end
        mem_ready = !withhold && (waited >= lat);
        waited++;
      end else begin
        act = 0;
        mem_ready = ($urandom_range(0, 3) == 0);
      end
    end
  end

  // Monitor: gathers each instruction's pulses from ir_load until retire, then scores them
  initial begin : monitor
    rec_t obs, e;
    bit active;
    int prev;
    active = 0; prev = 0; obs = '{default: 0};
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        active = 0; prev = 0;
        continue;
      end
      if (int'(instr_count) != prev) begin
        prev = int'(instr_count);
        active = 0;
        if (exp_q.size() == 0) begin
          checks++; fails++;
          $display("[TB] FAIL unexpected retire: count %0d with empty scoreboard", instr_count);
        end else begin
          e = exp_q.pop_front();
          checkOutput("pc_write", obs.pcw, e.pcw);
          checkOutput("pc_src", obs.pcsrc, e.pcsrc);
          checkOutput("rf_we cycles", obs.rfwe, e.rfwe);
          checkOutput("rf_link", obs.link, e.link);
          checkOutput("wb_sel", obs.wbsel, e.wbsel);
          checkOutput("data mem_req", obs.dmem, e.dmem);
          checkOutput("data mem_sel", obs.dsel, e.dsel);
          checkOutput("data mem_we", obs.dwe, e.dwe);
          checkOutput("data mem_req cycles", obs.dcyc, e.dcyc);
          checkOutput("instr_count", instr_count, e.count);
          checkOutput("state after retire", state, e.st);
          checkOutput("busy after retire", busy, e.st != 0);
        end
      end
      if (ir_load) begin
        checkOutput("fetch pc_write", pc_write, 1);
        checkOutput("fetch pc_src", pc_src, 0);
        checkOutput("fetch mem_sel", mem_sel, 0);
        checkOutput("fetch mem_we", mem_we, 0);
        obs = '{default: 0};
        active = 1;
      end else if (active) begin
        if (pc_write) begin obs.pcw = 1; obs.pcsrc = int'(pc_src); end
        if (rf_we) begin obs.rfwe++; obs.link |= rf_link; obs.wbsel = wb_sel; end
        if (mem_req) begin obs.dmem = 1; obs.dsel |= mem_sel; obs.dwe = mem_we; obs.dcyc++; end
      end
    end
  end

  task automatic applyReset();
    rst_n = 1'b0; start = 1'b0; withhold = 1'b0; fetch_lat = -1;
    repeat (3) @(negedge clk);
    prog.delete(); exp_q.delete(); exp_count = 0;
    rst_n = 1'b1;
  endtask

  // Runs the queued program to completion, restarting after each halt
  task automatic applyStimulus(input int budget);
    int cyc = 0;
    while ((prog.size() > 0 || state != 3'd0 || exp_q.size() > 0) && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (state == 3'd0 && prog.size() > 0) begin
        start = 1'b1;
        halt_req = 1'($urandom_range(0, 1));
      end else begin
        start = (state != 3'd0) ? 1'($urandom_range(0, 1)) : 1'b0;
      end
    end
    start = 1'b0;
    if (cyc >= budget) begin
      checks++; fails++;
      $display("[TB] FAIL program timeout: state %0d after %0d cycles", state, cyc);
    end
  endtask

  initial begin : watchdog_timer
    #500000;
    $display("[TB] FAIL simulation time limit reached");
    $fatal(1, "[TB] time limit");
  end

  initial begin : main
    int exp_trace[5] = '{1, 2, 3, 5, 1};
    int n, cyc;
    applyReset();
    checkOutput("reset state", state, 0);
    checkOutput("reset busy", busy, 0);
    checkOutput("reset error", error, 0);
    checkOutput("reset mem_req", mem_req, 0);
    checkOutput("reset instr_count", instr_count, 0);

    // add with same-cycle memory response, state trace
    fetch_lat = 0;
    prog.push_back(mk(T_ADD, 1'b0, 0, 1'b0));
    prog.push_back(mk(T_ADD, 1'b1, 0, 1'b0));
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      checkOutput($sformatf("add trace %0d", k), state, exp_trace[k]);
      @(negedge clk);
    end
    applyStimulus(200);

    // lw with delayed data, branches, jal with halt
    fetch_lat = -1;
    prog.push_back(mk(T_LW, 1'b0, 3, 1'b0));
    prog.push_back(mk(T_BEQ, 1'b0, 0, 1'b1));
    prog.push_back(mk(T_BNE, 1'b0, 0, 1'b1));
    prog.push_back(mk(T_SW, 1'b0, 2, 1'b0));
    prog.push_back(mk(T_JAL, 1'b1, 0, 1'b0));
    applyStimulus(400);

    // randomized program
    for (int k = 0; k < 40; k++)
      prog.push_back(mk($urandom_range(0, 7), (k == 39) || ($urandom_range(0, 5) == 0),
                        $urandom_range(0, 3), 1'($urandom_range(0, 1))));
    applyStimulus(5000);

    // ready on the last permitted fetch cycle beats the timeout
    fetch_lat = TO - 1;
    prog.push_back(mk(T_ADD, 1'b1, 0, 1'b0));
    applyStimulus(200);
    checkOutput("ready at timeout, error", error, 0);
    fetch_lat = -1;

    // fetch timeout
    withhold = 1'b1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    n = 0; cyc = 0;
    while (state != 3'd6 && cyc < 100) begin
      if (mem_req) n++;
      @(negedge clk);
      cyc++;
    end
    checkOutput("fetch wait cycles before error", n, TO);
    checkOutput("error state", state, 6);
    checkOutput("error flag", error, 1);
    checkOutput("error mem_req", mem_req, 0);
    checkOutput("error busy", busy, 0);
    withhold = 1'b0;
    start = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0;
    checkOutput("error sticky", state, 6);
    applyReset();
    checkOutput("state after error reset", state, 0);
    checkOutput("error after reset", error, 0);

    // asynchronous reset during a data access
    prog.push_back(mk(T_ADD, 1'b0, 0, 1'b0));
    prog.push_back(mk(T_LW, 1'b1, 10, 1'b0));
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    cyc = 0;
    while (state != 3'd4 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("reached MEM", state, 4);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async reset state", state, 0);
    checkOutput("async reset mem_req", mem_req, 0);
    checkOutput("async reset mem_sel", mem_sel, 0);
    checkOutput("async reset busy", busy, 0);
    checkOutput("async reset instr_count", instr_count, 0);
    repeat (2) @(negedge clk);
    prog.delete(); exp_q.delete(); exp_count = 0;
    rst_n = 1'b1;

    // counter wraps from all-ones back to zero
    for (int k = 0; k < (1 << CNT_W); k++)
      prog.push_back(mk(T_ADD, k == (1 << CNT_W) - 1, 0, 1'b0));
    applyStimulus(1000);
    checkOutput("count after wrap", instr_count, 0);
    checkOutput("scoreboard drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
